dec_n2n_seq: RTL and testbench

Registered, parametrised N-to-2^N one-hot decoder; the sequential successor to the combinational 2-to-4 decoder with enable. It has two modes. Direct mode accepts a select code over a valid/ready handshake and holds the decoded line for HOLD cycles. Scan mode walks all 2^N lines round-robin, as used for keypad-column or chip-select scanning.

---
 rtl/dec_n2n_seq.sv | 135 +++++++++++++
 tb/tb_dec_n2n_seq.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dec_n2n_seq.sv
// Registered N-to-2^N one-hot decoder with a direct (handshaked, held) mode and a round-robin scan mode.
// Optional macro DEC_N2N_ACTIVE_LOW_EN drives s inverted (idle = all ones, active line = 0).
module dec_n2n_seq #(
    parameter int N    = 2,
    parameter int HOLD = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic            mode,
    input  logic            a_valid,
    input  logic [N-1:0]    a,
    output logic            a_ready,
    output logic [2**N-1:0] s,
    output logic [N-1:0]    idx,
    output logic            busy,
    output logic            wrap
);
    localparam int LINES = 2**N;
    localparam int CW    = $clog2(HOLD + 1);
    localparam logic [CW-1:0] CNT_LOAD = CW'(HOLD - 1);
    localparam logic [N-1:0]  IDX_LAST = N'(LINES - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HOLD,
        ST_SCAN
    } state_t;

    state_t           state_q, state_d;
    logic [LINES-1:0] s_q, s_d;
    logic [N-1:0]     idx_q, idx_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             wrap_q, wrap_d;

    logic [N-1:0]     idx_inc;
    logic [LINES-1:0] hot_a;
    logic [LINES-1:0] hot_next;

    assign idx_inc = idx_q + N'(1);

    // One-hot images of the incoming code and of the next scan index.
    genvar gi;
    generate
        for (gi = 0; gi < LINES; gi++) begin : g_hot
            assign hot_a[gi]    = (a == N'(gi));
            assign hot_next[gi] = (idx_inc == N'(gi));
        end
    endgenerate

    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        wrap_d  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                s_d = '0;
                if (en && mode) begin
                    state_d = ST_SCAN;
                    s_d     = LINES'(1);
                    idx_d   = '0;
                    cnt_d   = CNT_LOAD;
                end else if (en && a_valid) begin
                    state_d = ST_HOLD;
                    s_d     = hot_a;
                    idx_d   = a;
                    cnt_d   = CNT_LOAD;
                end
            end
            ST_HOLD: begin
                if (!en || cnt_q == '0) begin
                    state_d = ST_IDLE;
                    s_d     = '0;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            ST_SCAN: begin
                // Dropping mode only takes effect once the current slot has run its full length.
                if (!en || (cnt_q == '0 && !mode)) begin
                    state_d = ST_IDLE;
                    s_d     = '0;
                    cnt_d   = '0;
                end else if (cnt_q == '0) begin
                    idx_d  = idx_inc;
                    s_d    = hot_next;
                    cnt_d  = CNT_LOAD;
                    wrap_d = (idx_q == IDX_LAST);
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                s_d     = '0;
                cnt_d   = '0;
            end
        endcase
        busy_d = |s_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            s_q     <= '0;
            idx_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            wrap_q  <= wrap_d;
        end
    end

    assign a_ready = (state_q == ST_IDLE) && en && !mode;
    assign idx     = idx_q;
    assign busy    = busy_q;
    assign wrap    = wrap_q;

`ifdef DEC_N2N_ACTIVE_LOW_EN
    assign s = ~s_q;
`else
    assign s = s_q;
`endif

endmodule

// File: tb/tb_dec_n2n_seq.sv
// Scoreboard bench for dec_n2n_seq: three instances (N=2/HOLD=3, N=2/HOLD=1, N=4/HOLD=2) on one clock.
// Output polarity follows DEC_N2N_ACTIVE_LOW_EN.
module tb_dec_n2n_seq;

`ifdef DEC_N2N_ACTIVE_LOW_EN
    localparam logic [15:0] POL = 16'hFFFF;
`else
    localparam logic [15:0] POL = 16'h0000;
`endif

    logic clk;
    logic rst;

    // Instance A: N=2, HOLD=3
    logic       en_a, mode_a, av_a, rdy_a, busy_a, wrap_a;
    logic [1:0] a_a, idx_a;
    logic [3:0] s_a;
    // Instance B: N=2, HOLD=1
    logic       en_b, mode_b, av_b, rdy_b, busy_b, wrap_b;
    logic [1:0] a_b, idx_b;
    logic [3:0] s_b;
    // Instance C: N=4, HOLD=2
    logic        en_c, mode_c, av_c, rdy_c, busy_c, wrap_c;
    logic [3:0]  a_c, idx_c;
    logic [15:0] s_c;

    typedef struct {
        logic [15:0] s;
        logic        busy;
        logic [3:0]  idx;
        logic        wrap;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    dec_n2n_seq #(.N(2), .HOLD(3)) u_a (
        .clk(clk), .rst(rst), .en(en_a), .mode(mode_a), .a_valid(av_a), .a(a_a),
        .a_ready(rdy_a), .s(s_a), .idx(idx_a), .busy(busy_a), .wrap(wrap_a)
    );

    dec_n2n_seq #(.N(2), .HOLD(1)) u_b (
        .clk(clk), .rst(rst), .en(en_b), .mode(mode_b), .a_valid(av_b), .a(a_b),
        .a_ready(rdy_b), .s(s_b), .idx(idx_b), .busy(busy_b), .wrap(wrap_b)
    );

    dec_n2n_seq #(.N(4), .HOLD(2)) u_c (
        .clk(clk), .rst(rst), .en(en_c), .mode(mode_c), .a_valid(av_c), .a(a_c),
        .a_ready(rdy_c), .s(s_c), .idx(idx_c), .busy(busy_c), .wrap(wrap_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic push_exp(input logic [15:0] s, input logic [3:0] idx, input logic wrap);
        exp_t e;
        e.s    = s;
        e.busy = (s != 16'h0);
        e.idx  = idx;
        e.wrap = wrap;
        sb_q.push_back(e);
    endtask

    task automatic test_reset();
        @(negedge clk);
        en_b   = 1'b1;
        mode_b = 1'b1;
        repeat (3) @(negedge clk);
        @(posedge clk);
        #1;
        checks++;
        if (s_b !== (4'b1000 ^ POL[3:0]) || busy_b !== 1'b1) begin
            errors++;
            $display("FAIL reset_pre s=%b busy=%b expected s=%b busy=1", s_b, busy_b, 4'b1000 ^ POL[3:0]);
        end
        #1;
        rst = 1'b1;
        #1;
        checks++;
        if (s_b !== POL[3:0] || busy_b !== 1'b0 || wrap_b !== 1'b0 || idx_b !== 2'd0) begin
            errors++;
            $display("FAIL reset_async s=%b busy=%b wrap=%b idx=%0d expected s=%b busy=0 wrap=0 idx=0",
                     s_b, busy_b, wrap_b, idx_b, POL[3:0]);
        end
        en_b   = 1'b0;
        mode_b = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (rdy_a !== 1'b0 || rdy_b !== 1'b0 || s_a !== POL[3:0] || busy_a !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle rdy_a=%b rdy_b=%b s_a=%b busy_a=%b expected rdy=0 s=%b busy=0",
                     rdy_a, rdy_b, s_a, busy_a, POL[3:0]);
        end
        $display("reset: async clear and idle after release done");
    endtask

    task automatic test_direct();
        exp_t e;
        int   wait_cnt;
        en_a   = 1'b1;
        mode_a = 1'b0;
        @(negedge clk);
        for (int code = 0; code < 4; code++) begin
            wait_cnt = 0;
            while (rdy_a !== 1'b1 && wait_cnt < 20) begin
                @(negedge clk);
                wait_cnt++;
            end
            checks++;
            if (rdy_a !== 1'b1) begin
                errors++;
                $display("FAIL direct_ready_timeout code=%0d rdy=%b expected 1", code, rdy_a);
            end
            av_a = 1'b1;
            a_a  = 2'(code);
            for (int k = 0; k < 3; k++) push_exp(16'(1 << code), 4'(code), 1'b0);
            push_exp(16'h0, 4'(code), 1'b0);
            for (int k = 0; k < 4; k++) begin
                @(negedge clk);
                av_a = 1'b0;
                e = sb_q.pop_front();
                checks++;
                if (s_a !== (e.s[3:0] ^ POL[3:0]) || busy_a !== e.busy || idx_a !== e.idx[1:0] ||
                    wrap_a !== e.wrap || rdy_a !== !e.busy) begin
                    errors++;
                    $display("FAIL direct code=%0d cyc=%0d s=%b busy=%b idx=%0d wrap=%b rdy=%b expected s=%b busy=%b idx=%0d wrap=%b rdy=%b",
                             code, k, s_a, busy_a, idx_a, wrap_a, rdy_a,
                             e.s[3:0] ^ POL[3:0], e.busy, e.idx[1:0], e.wrap, !e.busy);
                end
            end
            $display("direct: code %0d decoded and held", code);
        end
    endtask

    task automatic test_scan_wrap();
        exp_t e;
        @(negedge clk);
        en_b   = 1'b1;
        mode_b = 1'b1;
        for (int k = 0; k < 9; k++) push_exp(16'(1 << (k % 4)), 4'(k % 4), (k > 0) && (k % 4 == 0));
        push_exp(16'h0, 4'd0, 1'b0);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            e = sb_q.pop_front();
            checks++;
            if (s_b !== (e.s[3:0] ^ POL[3:0]) || busy_b !== e.busy || idx_b !== e.idx[1:0] || wrap_b !== e.wrap) begin
                errors++;
                $display("FAIL scan_wrap cyc=%0d s=%b busy=%b idx=%0d wrap=%b expected s=%b busy=%b idx=%0d wrap=%b",
                         k, s_b, busy_b, idx_b, wrap_b, e.s[3:0] ^ POL[3:0], e.busy, e.idx[1:0], e.wrap);
            end
            if (k == 8) en_b = 1'b0;
        end
        mode_b = 1'b0;
        $display("scan_wrap: 9 scan slots with wrap, then abort");
    endtask

    task automatic test_abort();
        exp_t e;
        int   wait_cnt;
        wait_cnt = 0;
        while (rdy_a !== 1'b1 && wait_cnt < 20) begin
            @(negedge clk);
            wait_cnt++;
        end
        checks++;
        if (rdy_a !== 1'b1) begin
            errors++;
            $display("FAIL abort_ready_timeout rdy=%b expected 1", rdy_a);
        end
        av_a = 1'b1;
        a_a  = 2'd2;
        push_exp(16'h0004, 4'd2, 1'b0);
        push_exp(16'h0000, 4'd2, 1'b0);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            av_a = 1'b0;
            e = sb_q.pop_front();
            checks++;
            if (s_a !== (e.s[3:0] ^ POL[3:0]) || busy_a !== e.busy || idx_a !== e.idx[1:0] ||
                (k == 1 && rdy_a !== 1'b0)) begin
                errors++;
                $display("FAIL abort cyc=%0d s=%b busy=%b idx=%0d rdy=%b expected s=%b busy=%b idx=%0d",
                         k, s_a, busy_a, idx_a, rdy_a, e.s[3:0] ^ POL[3:0], e.busy, e.idx[1:0]);
            end
            if (k == 0) en_a = 1'b0;
        end
        $display("abort: hold of code 2 cut short by en");
    endtask

    task automatic test_mode_change();
        exp_t e;
        @(negedge clk);
        en_a   = 1'b1;
        mode_a = 1'b1;
        for (int k = 0; k < 3; k++) push_exp(16'h0001, 4'd0, 1'b0);
        for (int k = 0; k < 3; k++) push_exp(16'h0002, 4'd1, 1'b0);
        push_exp(16'h0000, 4'd1, 1'b0);
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            e = sb_q.pop_front();
            checks++;
            if (s_a !== (e.s[3:0] ^ POL[3:0]) || busy_a !== e.busy || idx_a !== e.idx[1:0] ||
                wrap_a !== e.wrap || (k == 6 && rdy_a !== 1'b1)) begin
                errors++;
                $display("FAIL mode_change cyc=%0d s=%b busy=%b idx=%0d wrap=%b rdy=%b expected s=%b busy=%b idx=%0d wrap=%b",
                         k, s_a, busy_a, idx_a, wrap_a, rdy_a, e.s[3:0] ^ POL[3:0], e.busy, e.idx[1:0], e.wrap);
            end
            if (k == 3) mode_a = 1'b0;
        end
        $display("mode_change: slot 1 completed after mode cleared");
    endtask

    task automatic test_wide();
        exp_t e;
        @(negedge clk);
        en_c   = 1'b1;
        mode_c = 1'b0;
        av_c   = 1'b1;
        a_c    = 4'hA;
        push_exp(16'h0400, 4'hA, 1'b0);
        push_exp(16'h0400, 4'hA, 1'b0);
        push_exp(16'h0000, 4'hA, 1'b0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            av_c = 1'b0;
            e = sb_q.pop_front();
            checks++;
            if (s_c !== (e.s ^ POL) || busy_c !== e.busy || idx_c !== e.idx || wrap_c !== e.wrap ||
                rdy_c !== !e.busy) begin
                errors++;
                $display("FAIL wide cyc=%0d s=%h busy=%b idx=%0d wrap=%b rdy=%b expected s=%h busy=%b idx=%0d wrap=%b",
                         k, s_c, busy_c, idx_c, wrap_c, rdy_c, e.s ^ POL, e.busy, e.idx, e.wrap);
            end
        end
        $display("wide: code 0xA on 16 lines");
    endtask

    initial begin
        rst    = 1'b1;
        en_a   = 1'b0; mode_a = 1'b0; av_a = 1'b0; a_a = '0;
        en_b   = 1'b0; mode_b = 1'b0; av_b = 1'b0; a_b = '0;
        en_c   = 1'b0; mode_c = 1'b0; av_c = 1'b0; a_c = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        test_reset();
        test_direct();
        test_scan_wrap();
        test_abort();
        test_mode_change();
        test_wide();

        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain left=%0d expected 0", sb_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
